// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller: tracks in-flight destinations, picks forwarding sources,
// stalls on load-use, squashes younger slots after a redirect and counts stalls/flushes.
module pipe_hazard_unit #(
  parameter int REG_AW      = 4,
  parameter int FWD_STAGES  = 3,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16,
  parameter int SEL_W       = $clog2(FWD_STAGES + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs_addr,
  input  logic              i_id_rs_used,
  input  logic [REG_AW-1:0] i_id_rt_addr,
  input  logic              i_id_rt_used,
  input  logic              i_id_wr_en,
  input  logic [REG_AW-1:0] i_id_wr_addr,
  input  logic              i_id_is_load,
  input  logic              i_redirect,
  input  logic              i_perf_clr,
  output logic              o_stall,
  output logic              o_id_kill,
  output logic [SEL_W-1:0]  o_fwd_rs_sel,
  output logic [SEL_W-1:0]  o_fwd_rt_sel,
  output logic [CNT_W-1:0]  o_perf_stall_cnt,
  output logic [CNT_W-1:0]  o_perf_flush_cnt
);

  localparam int FL_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

  logic [FWD_STAGES:1] r_vld;
  logic [FWD_STAGES:1] r_load;
  logic [REG_AW-1:0]   r_addr [1:FWD_STAGES];
  logic [FL_W-1:0]     r_flush_cnt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_evt_cnt;

  logic [FWD_STAGES:1] w_rs_hit;
  logic [FWD_STAGES:1] w_rt_hit;
  logic [SEL_W-1:0]    w_rs_sel;
  logic [SEL_W-1:0]    w_rt_sel;
  logic                w_rs_haz;
  logic                w_rt_haz;
  logic                w_kill;
  logic                w_stall;
  logic                w_issue;

  genvar gi;
  generate
    for (gi = 1; gi <= FWD_STAGES; gi++) begin : g_match
      assign w_rs_hit[gi] = i_id_rs_used & r_vld[gi] & (r_addr[gi] == i_id_rs_addr);
      assign w_rt_hit[gi] = i_id_rt_used & r_vld[gi] & (r_addr[gi] == i_id_rt_addr);
    end
  endgenerate

  // Scan oldest to youngest so the youngest matching stage is the last one written.
  always_comb begin
    w_rs_sel = '0;
    w_rt_sel = '0;
    w_rs_haz = 1'b0;
    w_rt_haz = 1'b0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (w_rs_hit[k]) begin
        w_rs_sel = SEL_W'(k);
        w_rs_haz = r_load[k] && (k <= LOAD_LAT);
      end
      if (w_rt_hit[k]) begin
        w_rt_sel = SEL_W'(k);
        w_rt_haz = r_load[k] && (k <= LOAD_LAT);
      end
    end
  end

  assign w_kill  = i_redirect | (r_flush_cnt != '0);
  assign w_stall = i_id_valid & ~w_kill & (w_rs_haz | w_rt_haz);
  assign w_issue = i_id_valid & i_id_wr_en & ~w_stall & ~w_kill;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld  <= '0;
      r_load <= '0;
      for (int k = 1; k <= FWD_STAGES; k++) r_addr[k] <= '0;
    end else begin
      r_vld[1]  <= w_issue;
      r_load[1] <= w_issue & i_id_is_load;
      r_addr[1] <= i_id_wr_addr;
      for (int k = 2; k <= FWD_STAGES; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_load[k] <= r_load[k-1];
        r_addr[k] <= r_addr[k-1];
      end
    end
  end

  // A redirect restarts the window rather than extending it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flush_cnt <= '0;
    end else if (i_redirect) begin
      r_flush_cnt <= FL_W'(FLUSH_DEPTH - 1);
    end else if (r_flush_cnt != '0) begin
      r_flush_cnt <= r_flush_cnt - FL_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt     <= '0;
      r_flush_evt_cnt <= '0;
    end else if (i_perf_clr) begin
      r_stall_cnt     <= '0;
      r_flush_evt_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (i_redirect && (r_flush_evt_cnt != '1))
        r_flush_evt_cnt <= r_flush_evt_cnt + CNT_W'(1);
    end
  end

  assign o_stall          = w_stall;
  assign o_id_kill        = w_kill;
  assign o_fwd_rs_sel     = i_id_valid ? w_rs_sel : '0;
  assign o_fwd_rt_sel     = i_id_valid ? w_rt_sel : '0;
  assign o_perf_stall_cnt = r_stall_cnt;
  assign o_perf_flush_cnt = r_flush_evt_cnt;

endmodule
